// File: rtl/tm1638_pkg.sv
// Shared command bytes and state encodings for the TM1638 serial refresh block.
package tm1638_pkg;

  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [3:0] CMD_DISP       = 4'b1000;

  typedef enum logic [2:0] {IDLE, MODE, ADDR, DISP, KEY} state_e;

  // Position inside one STB-low segment plus the trailing STB-high gap.
  typedef enum logic [2:0] {PH_PRE, PH_BYTES, PH_WAIT, PH_POST, PH_GAP} phase_e;

endpackage

// File: rtl/tm1638_byte_shifter.sv
// One-byte LSB-first serial shifter: H cycles low, H cycles high per bit;
// samples the input line on every low-to-high transition.
module tm1638_byte_shifter #(
  parameter int unsigned H = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       sio_data_in,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       sdo,
  output logic [7:0] rx_byte
);

  localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;

  logic          busy_q, busy_d;
  logic          half_q, half_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rx_q, rx_d;
  logic          last_cyc;

  assign last_cyc = (cnt_q == CW'(H - 1));

  always_comb begin
    busy_d = busy_q;
    half_d = half_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    done   = busy_q && half_q && last_cyc && (bit_q == 3'd7);
    if (busy_q) begin
      if (last_cyc) begin
        cnt_d  = '0;
        half_d = !half_q;
        if (!half_q) begin
          rx_d = {sio_data_in, rx_q[7:1]};
        end else begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) busy_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A start on the done cycle chains the next byte with no idle gap.
    if (start) begin
      busy_d = 1'b1;
      half_d = 1'b0;
      cnt_d  = '0;
      bit_d  = '0;
      sh_d   = tx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      half_q <= 1'b0;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '1;
      rx_q   <= '0;
    end else begin
      busy_q <= busy_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
    end
  end

  assign busy    = busy_q;
  assign sclk    = busy_q ? half_q : 1'b1;
  assign sdo     = busy_q ? sh_q[0] : 1'b1;
  assign rx_byte = rx_q;

endmodule

// File: rtl/tm1638_serial_tx.sv
// Continuous TM1638 display refresh over STB/CLK/DIO.
// Optional key-scan readback enabled by defining TM1638_KEY_READ_EN.
module tm1638_serial_tx
  import tm1638_pkg::*;
#(
  parameter int unsigned clk_mhz  = 50,
  parameter int unsigned sclk_khz = 500,
  parameter int unsigned w_digit  = 8,
  parameter int unsigned w_seg    = 8,
  parameter int unsigned w_led    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [w_seg-1:0] hex [w_digit],
  input  logic [w_led-1:0] led,
  input  logic [2:0]       brightness,
  input  logic             display_on,
  output logic             sio_stb,
  output logic             sio_clk,
  output logic             sio_data_out,
  output logic             sio_data_oe,
  input  logic             sio_data_in,
  output logic [7:0]       keys,
  output logic             frame_done
);

  localparam int unsigned H  = clk_mhz * 1000 / (2 * sclk_khz);
  localparam int unsigned TW = (H > 0) ? $clog2(2 * H + 1) : 1;

  if (H < 1) begin : g_h_check
    $error("tm1638_serial_tx: half-period H must be at least one clk cycle");
  end

`ifdef TM1638_KEY_READ_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [4:0]       bidx_q, bidx_d;
  logic [w_seg-1:0] hex_q [w_digit];
  logic [w_seg-1:0] hex_d [w_digit];
  logic [w_led-1:0] led_q, led_d;
  logic [2:0]       bri_q, bri_d;
  logic             don_q, don_d;

  logic       want_start, sh_start, sh_busy, sh_done, sh_sclk, sh_sdo;
  logic [7:0] tx_byte, rx_byte;
  logic [4:0] sel_idx, last_idx;
  logic       h_end, gap_end;

`ifdef TM1638_KEY_READ_EN
  logic       oe_q, oe_d;
  logic [7:0] keys_q, keys_d;
  logic [7:0] kacc_q, kacc_d;
  logic [1:0] kb;
  assign kb = bidx_q[1:0] - 2'd1;
`else
  logic unused_rx;
  assign unused_rx = ^rx_byte;
`endif

  assign h_end    = (tmr_q == TW'(H - 1));
  assign gap_end  = (tmr_q == TW'(2 * H - 1));
  assign sel_idx  = (phase_q == PH_PRE) ? 5'd0 : bidx_q + 5'd1;
  assign last_idx = (state_q == ADDR) ? 5'd16 : (state_q == KEY) ? 5'd4 : 5'd0;
  assign sh_start = want_start && (!sh_busy || sh_done);

  // Byte about to be launched: index sel_idx within the current segment.
  always_comb begin
    int unsigned pos;
    pos     = (32'(sel_idx) - 1) >> 1;
    tx_byte = 8'hFF;
    case (state_q)
      MODE: tx_byte = CMD_WRITE_AUTO;
      ADDR: begin
        if (sel_idx == 5'd0) begin
          tx_byte = CMD_ADDR0;
        end else begin
          tx_byte = '0;
          if (sel_idx[0]) begin
            for (int unsigned i = 0; i < w_digit; i++)
              if (pos == i) tx_byte = 8'(hex_q[i]);
          end else begin
            for (int unsigned i = 0; i < w_led; i++)
              if (pos == i) tx_byte = {7'b0, led_q[i]};
          end
        end
      end
      DISP: tx_byte = {CMD_DISP, don_q, bri_q};
      KEY:  tx_byte = (sel_idx == 5'd0) ? CMD_READ_KEYS : 8'hFF;
      default: tx_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tmr_d      = tmr_q + 1'b1;
    bidx_d     = bidx_q;
    hex_d      = hex_q;
    led_d      = led_q;
    bri_d      = bri_q;
    don_d      = don_q;
    want_start = 1'b0;
    frame_done = 1'b0;
`ifdef TM1638_KEY_READ_EN
    oe_d   = oe_q;
    keys_d = keys_q;
    kacc_d = kacc_q;
`endif
    if (state_q == IDLE) begin
      hex_d   = hex;
      led_d   = led;
      bri_d   = brightness;
      don_d   = display_on;
      state_d = MODE;
      phase_d = PH_PRE;
      tmr_d   = '0;
    end else begin
      case (phase_q)
        PH_PRE: if (h_end) begin
          want_start = 1'b1;
          phase_d    = PH_BYTES;
          bidx_d     = '0;
        end
        PH_BYTES: if (sh_done) begin
`ifdef TM1638_KEY_READ_EN
          if (state_q == KEY && bidx_q != 5'd0) begin
            kacc_d[{kb, 1'b0}] = rx_byte[0];
            kacc_d[{kb, 1'b1}] = rx_byte[4];
          end
`endif
          if (bidx_q == last_idx) begin
            phase_d = PH_POST;
            tmr_d   = '0;
          end else if (state_q == KEY && bidx_q == 5'd0) begin
            phase_d = PH_WAIT;
            tmr_d   = '0;
`ifdef TM1638_KEY_READ_EN
            oe_d    = 1'b0;
`endif
          end else begin
            want_start = 1'b1;
            bidx_d     = sel_idx;
          end
        end
        PH_WAIT: if (gap_end) begin
          want_start = 1'b1;
          phase_d    = PH_BYTES;
          bidx_d     = sel_idx;
        end
        PH_POST: if (h_end) begin
          phase_d = PH_GAP;
          tmr_d   = '0;
`ifdef TM1638_KEY_READ_EN
          if (state_q == KEY) begin
            keys_d = kacc_q;
            oe_d   = 1'b1;
          end
`endif
        end
        PH_GAP: if (gap_end) begin
          phase_d    = PH_PRE;
          tmr_d      = '0;
          frame_done = (state_q == KEY) || (state_q == DISP && !KEY_EN);
          case (state_q)
            MODE:    state_d = ADDR;
            ADDR:    state_d = DISP;
            DISP:    state_d = KEY_EN ? KEY : IDLE;
            default: state_d = IDLE;
          endcase
        end
        default: phase_d = PH_PRE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= PH_PRE;
      tmr_q   <= '0;
      bidx_q  <= '0;
      hex_q   <= '{default: '0};
      led_q   <= '0;
      bri_q   <= '0;
      don_q   <= 1'b0;
`ifdef TM1638_KEY_READ_EN
      oe_q    <= 1'b1;
      keys_q  <= '0;
      kacc_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tmr_q   <= tmr_d;
      bidx_q  <= bidx_d;
      hex_q   <= hex_d;
      led_q   <= led_d;
      bri_q   <= bri_d;
      don_q   <= don_d;
`ifdef TM1638_KEY_READ_EN
      oe_q    <= oe_d;
      keys_q  <= keys_d;
      kacc_q  <= kacc_d;
`endif
    end
  end

  tm1638_byte_shifter #(.H(H)) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (sh_start),
    .tx_byte     (tx_byte),
    .sio_data_in (sio_data_in),
    .busy        (sh_busy),
    .done        (sh_done),
    .sclk        (sh_sclk),
    .sdo         (sh_sdo),
    .rx_byte     (rx_byte)
  );

  assign sio_stb      = !(state_q != IDLE && phase_q != PH_GAP);
  assign sio_clk      = sh_sclk;
  assign sio_data_out = sh_sdo;
`ifdef TM1638_KEY_READ_EN
  assign sio_data_oe  = oe_q;
  assign keys         = keys_q;
`else
  assign sio_data_oe  = 1'b1;
  assign keys         = '0;
`endif

endmodule

// File: tb/tb_tm1638_serial_tx.sv
// Bench for tm1638_serial_tx: a TM1638 bus model collects bytes per STB frame
// and compares them with frames built from the snapshot rules.
module tb_tm1638_serial_tx;

  localparam int H         = 2;
  localparam int FRAME_CYC = 316 * H + 1;
`ifdef TM1638_KEY_READ_EN
  localparam int NSEG = 4;
`else
  localparam int NSEG = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] hex [8];
  logic [7:0] led;
  logic [2:0] brightness;
  logic       display_on;
  logic       sio_stb, sio_clk, sio_data_out, sio_data_oe, sio_data_in;
  logic [7:0] keys;
  logic       frame_done;

  always #5 clk = ~clk;

  tm1638_serial_tx #(.clk_mhz(4), .sclk_khz(1000), .w_digit(8), .w_seg(8), .w_led(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hex          (hex),
    .led          (led),
    .brightness   (brightness),
    .display_on   (display_on),
    .sio_stb      (sio_stb),
    .sio_clk      (sio_clk),
    .sio_data_out (sio_data_out),
    .sio_data_oe  (sio_data_oe),
    .sio_data_in  (sio_data_in),
    .keys         (keys),
    .frame_done   (frame_done)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bus model state
  logic [7:0]  byte_q [$];
  int          seg_len_q [$];
  logic [7:0]  cur;
  int          nbits, seg_bytes, run, rbit, rd_bits;
  int          phase_bad = 0, partial_bad = 0;
  bit          hi_edge;
  logic        prev_stb, prev_sck;
  logic [31:0] resp = 32'h01_10_00_11;
  int          cyc = 0;

  assign sio_data_in = (rbit < 32) ? resp[rbit] : 1'b1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    rbit = 0;
    rd_bits = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur = '0; nbits = 0; seg_bytes = 0; run = 0; hi_edge = 0; rbit = 0;
        prev_stb = 1'b1; prev_sck = 1'b1;
      end else begin
        if (!sio_stb) begin
          if (!prev_sck && sio_clk) begin
            if (run != H) phase_bad++;
            hi_edge = 1; run = 1;
            if (sio_data_oe) begin
              cur = {sio_data_out, cur[7:1]};
              nbits++;
              if (nbits == 8) begin
                byte_q.push_back(cur);
                seg_bytes++;
                nbits = 0;
              end
            end else begin
              rbit++;
              rd_bits++;
            end
          end else if (prev_sck && !sio_clk) begin
            if (hi_edge && run != H) phase_bad++;
            hi_edge = 0; run = 1;
          end else begin
            run++;
          end
        end
        if (!prev_stb && sio_stb) begin
          if (nbits != 0) partial_bad++;
          seg_len_q.push_back(seg_bytes);
          seg_bytes = 0; nbits = 0; rbit = 0; hi_edge = 0;
        end
        prev_stb = sio_stb;
        prev_sck = sio_clk;
      end
    end
  end

  // Reference frame from the current input values
  logic [7:0] exp_bytes [$];
  int         exp_segs [$];
  logic [7:0] exp_keys;
  int         last_done;

  task automatic build_expected();
    exp_bytes.delete();
    exp_segs = {1, 17, 1};
    exp_bytes.push_back(8'h40);
    exp_bytes.push_back(8'hC0);
    for (int i = 0; i < 8; i++) begin
      exp_bytes.push_back(hex[i]);
      exp_bytes.push_back({7'b0, led[i]});
    end
    exp_bytes.push_back({4'b1000, display_on, brightness});
`ifdef TM1638_KEY_READ_EN
    exp_bytes.push_back(8'h42);
    exp_segs.push_back(1);
`endif
    for (int b = 0; b < 4; b++) begin
      exp_keys[2*b]   = resp[8*b];
      exp_keys[2*b+1] = resp[8*b+4];
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 8; i++) hex[i] = 8'($urandom);
    led        = 8'($urandom);
    brightness = 3'($urandom);
    display_on = 1'($urandom);
  endtask

  task automatic do_frame(input int mid_at);
    bit got_done;
    build_expected();
    got_done = 0;
    for (int c = 0; c < 3 * FRAME_CYC; c++) begin
      @(negedge clk); #1;
      if (c == mid_at) hex[3] = ~hex[3];
      if (frame_done) begin
        got_done = 1;
        break;
      end
    end
    check_eq("frame_done_seen", 32'(got_done), 32'd1);
    if (got_done) begin
      check_eq("seg_count", 32'(seg_len_q.size()), 32'(NSEG));
      for (int i = 0; i < NSEG && i < seg_len_q.size(); i++)
        check_eq($sformatf("seg_len%0d", i), 32'(seg_len_q[i]), 32'(exp_segs[i]));
      check_eq("byte_count", 32'(byte_q.size()), 32'(exp_bytes.size()));
      for (int i = 0; i < exp_bytes.size() && i < byte_q.size(); i++)
        check_eq($sformatf("byte%0d", i), 32'(byte_q[i]), 32'(exp_bytes[i]));
      check_eq("clk_phase_len", 32'(phase_bad), 32'd0);
      check_eq("partial_byte", 32'(partial_bad), 32'd0);
`ifdef TM1638_KEY_READ_EN
      check_eq("keys", 32'(keys), 32'(exp_keys));
      check_eq("read_bits_oe_low", 32'(rd_bits), 32'd32);
`else
      if (last_done >= 0)
        check_eq("frame_period", 32'(cyc - last_done), 32'(FRAME_CYC));
      check_eq("keys_tied", 32'(keys), 32'd0);
`endif
      last_done = cyc;
    end
    rd_bits = 0;
    byte_q.delete();
    seg_len_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    last_done = -1;
    for (int i = 0; i < 8; i++) hex[i] = 8'h00;
    hex[0]     = 8'h3F;
    led        = 8'h01;
    brightness = 3'($urandom_range(0, 7));
    display_on = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_stb", 32'(sio_stb), 32'd1);
    check_eq("rst_clk", 32'(sio_clk), 32'd1);
    check_eq("rst_dout", 32'(sio_data_out), 32'd1);
    check_eq("rst_oe", 32'(sio_data_oe), 32'd1);
    check_eq("rst_keys", 32'(keys), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    do_frame(-1);
    brightness = 3'd5; display_on = 1'b1;
    do_frame(-1);
    display_on = 1'b0;
    do_frame(-1);

    // Mid-ADDR change: visible only from the following frame
    randomize_inputs();
    do_frame(150);
    do_frame(-1);

    for (int k = 0; k < 6; k++) begin
      randomize_inputs();
      do_frame(-1);
    end

    // Reset in the middle of an ADDR data byte
    randomize_inputs();
    repeat (100) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_stb", 32'(sio_stb), 32'd1);
    check_eq("abort_clk", 32'(sio_clk), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    byte_q.delete();
    seg_len_q.delete();
    rd_bits = 0;
    last_done = -1;
    randomize_inputs();
    rst_n = 1'b1;
    do_frame(-1);
    do_frame(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
